pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer_pkg.sv | 29 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared state encoding, drain depth and control bundle for the sequencer
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } seq_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                                 mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};

  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
                                    mem_wb_en: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear over increment
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - five-stage pipeline enable/flush sequencer with memory wait, drain and halt
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  seq_state_e state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  ctrl_t ctrl;
  logic wait_now;
  logic stall_inc;

  always_comb begin
    ctrl     = CTRL_RUN;
    state_d  = state_q;
    drain_d  = drain_q;
    wait_now = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        // Once in MEM_WAIT only ready matters; the request is already committed.
        wait_now = (state_q == ST_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
        if (wait_now) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (br_taken) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          state_d           = ST_RUN;
        end else if (hz_stall) begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
          state_d           = ST_RUN;
        end else if (halt_req) begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          drain_d           = DW'(DRAIN_CYCLES);
          state_d           = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (dmem_req && !dmem_ready) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
          drain_d           = (drain_q != '0) ? drain_q - 1'b1 : '0;
          if (drain_q <= DW'(1)) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        ctrl = CTRL_FREEZE;
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign stall_inc = !ctrl.pc_en && (state_q != ST_HALTED);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  // Reset holds every stage frozen and forces NOP/bubble into the front registers.
  assign pc_en        = rst_n & ctrl.pc_en;
  assign if_id_en     = rst_n & ctrl.if_id_en;
  assign id_ex_en     = rst_n & ctrl.id_ex_en;
  assign ex_mem_en    = rst_n & ctrl.ex_mem_en;
  assign mem_wb_en    = rst_n & ctrl.mem_wb_en;
  assign if_id_flush  = !rst_n | ctrl.if_id_flush;
  assign id_ex_bubble = !rst_n | ctrl.id_ex_bubble;
  assign state        = state_q;

endmodule
